fifo_rd_ctrl: RTL and testbench



---
 rtl/fifo_rd_ctrl_if.sv | 27 ++
 rtl/fifo_rd_ctrl.sv | 98 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO bus: write-pointer exchange, dual_port_ram read port,
// first-word-fall-through stream and occupancy status.
interface fifo_rd_ctrl_if #(
  parameter int RAM_ADDR_WIDTH = 5,
  parameter int RAM_DATA_WIDTH = 8
);
  logic [RAM_ADDR_WIDTH:0]   wr_ptr;
  logic [RAM_ADDR_WIDTH:0]   rd_ptr;
  logic                      ram_rd_port_ena;
  logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr;
  logic [RAM_DATA_WIDTH-1:0] ram_rd_data;
  logic [RAM_DATA_WIDTH-1:0] m_data;
  logic                      m_valid;
  logic                      m_ready;
  logic                      empty;
  logic [RAM_ADDR_WIDTH:0]   rd_count;

  modport master (
    input  wr_ptr, ram_rd_data, m_ready,
    output rd_ptr, ram_rd_port_ena, ram_rd_addr, m_data, m_valid, empty, rd_count
  );

  modport slave (
    output wr_ptr, ram_rd_data, m_ready,
    input  rd_ptr, ram_rd_port_ena, ram_rd_addr, m_data, m_valid, empty, rd_count
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// UART FIFO read controller: fetches from dual_port_ram through a 2-entry
// head/skid buffer so the FWFT stream sustains one word per cycle.
module fifo_rd_ctrl #(
  parameter int RAM_DEPTH      = 32,
  parameter int RAM_ADDR_WIDTH = 5,
  parameter int RAM_DATA_WIDTH = 8
) (
  input  logic           rd_clk,
  input  logic           rd_rst,
  fifo_rd_ctrl_if.master bus
);
  localparam int PW = RAM_ADDR_WIDTH + 1;
  localparam int DW = RAM_DATA_WIDTH;

  typedef enum logic [1:0] {BUF0 = 2'd0, BUF1 = 2'd1, BUF2 = 2'd2} occ_e;

  occ_e          occ_q, occ_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] buf0_q, buf0_d;
  logic [DW-1:0] buf1_q, buf1_d;

  logic       m_valid, pop, ram_avail, fetch;
  logic [1:0] occ_cnt, level;
  logic       ld0_ram, ld0_skid, ld1_ram;

  assign occ_cnt   = occ_q;
  assign m_valid   = (occ_q != BUF0);
  assign pop       = m_valid & bus.m_ready;
  assign ram_avail = (bus.wr_ptr != rd_ptr_q);
  // Words that will sit in the buffer next cycle if nothing new is fetched.
  assign level     = occ_cnt + {1'b0, inflight_q} - {1'b0, pop};
  assign fetch     = ram_avail & (level < 2'd2) & ~rd_rst;

  // State register
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      occ_q      <= BUF0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      assert (occ_cnt + {1'b0, inflight_q} <= 2'd2);
      assert (RAM_DEPTH == (1 << RAM_ADDR_WIDTH));
    end
  end

  // Next-state: occupancy of the head/skid buffer
  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      BUF0: if (inflight_q) occ_d = BUF1;
      BUF1: begin
        if (pop && !inflight_q)      occ_d = BUF0;
        else if (!pop && inflight_q) occ_d = BUF2;
      end
      BUF2: if (pop) occ_d = BUF1;
      default: occ_d = BUF0;
    endcase
  end

  // Output decode: which buffer slot captures returning RAM data
  always_comb begin
    ld0_ram  = 1'b0;
    ld0_skid = 1'b0;
    ld1_ram  = 1'b0;
    case (occ_q)
      BUF0: ld0_ram = inflight_q;
      BUF1: begin
        ld0_ram = inflight_q & pop;
        ld1_ram = inflight_q & ~pop;
      end
      BUF2:    ld0_skid = pop;
      default: ;
    endcase
  end

  always_comb begin
    buf0_d     = ld0_ram ? bus.ram_rd_data : (ld0_skid ? buf1_q : buf0_q);
    buf1_d     = ld1_ram ? bus.ram_rd_data : buf1_q;
    rd_ptr_d   = fetch ? rd_ptr_q + PW'(1) : rd_ptr_q;
    inflight_d = fetch;
  end

  assign bus.rd_ptr          = rd_ptr_q;
  assign bus.ram_rd_port_ena = fetch;
  assign bus.ram_rd_addr     = rd_ptr_q[RAM_ADDR_WIDTH-1:0];
  assign bus.m_data          = buf0_q;
  assign bus.m_valid         = m_valid;
  assign bus.empty           = ~ram_avail & ~inflight_q & (occ_q == BUF0);
  assign bus.rd_count        = (bus.wr_ptr - rd_ptr_q) + PW'(inflight_q) + PW'(occ_cnt);
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: RAM model with 1-cycle read, expected-word queue,
// negedge monitor popping on every accepted beat.
module tb_fifo_rd_ctrl;
  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW)) bus ();

  fifo_rd_ctrl #(.RAM_DEPTH(DEPTH), .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW)) dut (
    .rd_clk(clk),
    .rd_rst(rst),
    .bus   (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always @(posedge clk) if (bus.ram_rd_port_ena) bus.ram_rd_data <= mem[bus.ram_rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted beat must match the oldest written word
  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_extra: got %0h expected no word", bus.m_data);
      end else begin
        chk("stream_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  logic [AW-1:0] last_addr = '0;
  int wrap_cnt = 0;
  always @(negedge clk) begin
    if (bus.ram_rd_port_ena) begin
      if (last_addr == AW'(DEPTH - 1) && bus.ram_rd_addr == '0) wrap_cnt++;
      last_addr = bus.ram_rd_addr;
    end
  end

  task automatic wr_word(input logic [DW-1:0] d);
    mem[bus.wr_ptr[AW-1:0]] = d;
    bus.wr_ptr = bus.wr_ptr + PW'(1);
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.wr_ptr = '0;
    bus.m_ready = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.m_valid), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int v, bad, w0;
    bus.wr_ptr = '0;
    bus.m_ready = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_m_data", 32'(bus.m_data), 0);
    chk("rst_ena", 32'(bus.ram_rd_port_ena), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_count", 32'(bus.rd_count), 0);
    chk("rst_rd_ptr", 32'(bus.rd_ptr), 0);

    // Basic: one word, fetch in N, valid in N+2
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    wr_word(8'hA5);
    @(negedge clk);
    chk("basic_fetch_ena", 32'(bus.ram_rd_port_ena), 1);
    chk("basic_fetch_addr", 32'(bus.ram_rd_addr), 0);
    @(negedge clk);
    chk("basic_n1_valid", 32'(bus.m_valid), 0);
    chk("basic_n1_count", 32'(bus.rd_count), 1);
    @(negedge clk);
    chk("basic_n2_valid", 32'(bus.m_valid), 1);
    chk("basic_n2_data", 32'(bus.m_data), 32'hA5);
    @(negedge clk);
    chk("basic_empty", 32'(bus.empty), 1);
    chk("basic_count", 32'(bus.rd_count), 0);

    // Streaming: 16 preloaded words, one per cycle
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) wr_word(DW'(i));
    wait_valid("stream_first_valid");
    v = 0;
    repeat (16) begin
      if (bus.m_valid) v++;
      @(negedge clk);
    end
    chk("stream_gapless", v, 16);
    chk("stream_rd_ptr", 32'(bus.rd_ptr), 16);
    chk("stream_empty", 32'(bus.empty), 1);

    // Back-pressure: only two words fetched beyond RAM while stalled
    do_reset();
    for (int i = 0; i < 10; i++) wr_word(DW'(8'h40 + i));
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_data != 8'h40) bad++;
    end
    chk("bp_hold_stable", bad, 0);
    chk("bp_rd_ptr", 32'(bus.rd_ptr), 2);
    chk("bp_count", 32'(bus.rd_count), 10);
    chk("bp_head", 32'(bus.m_data), 32'h40);
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    v = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.m_valid) v++;
    end
    chk("bp_gapless", v, 10);
    @(negedge clk);
    chk("bp_empty", 32'(bus.empty), 1);

    // Wrap: 40 words, random consumer
    do_reset();
    w0 = wrap_cnt;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          while (PW'(bus.wr_ptr - bus.rd_ptr) >= PW'(DEPTH)) begin
            @(posedge clk); #1;
          end
          wr_word(DW'(i) ^ 8'h5A);
          @(posedge clk); #1;
        end
      end
      begin
        repeat (120) begin
          bus.m_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    bus.m_ready = 1'b1;
    wait_drain("wrap_drain");
    repeat (2) @(negedge clk);
    chk("wrap_rd_ptr", 32'(bus.rd_ptr), 40);
    chk("wrap_addr_wrapped", wrap_cnt - w0, 1);
    chk("wrap_empty", 32'(bus.empty), 1);

    // Full: 32 words in RAM, stalled consumer
    do_reset();
    for (int i = 0; i < 32; i++) wr_word(DW'(8'h80 + i));
    repeat (10) @(negedge clk);
    chk("full_count", 32'(bus.rd_count), 32);
    chk("full_rd_ptr", 32'(bus.rd_ptr), 2);
    chk("full_head", 32'(bus.m_data), 32'h80);
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    wait_drain("full_drain");
    @(negedge clk);
    chk("full_empty", 32'(bus.empty), 1);

    // Mid-operation reset with a buffered word and a fetch in flight
    do_reset();
    for (int i = 0; i < 5; i++) wr_word(DW'(i + 1));
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_pre_valid", 32'(bus.m_valid), 1);
    chk("mid_pre_count", 32'(bus.rd_count), 5);
    @(negedge clk);
    chk("mid_rst_no_fetch", 32'(bus.ram_rd_port_ena), 0);
    chk("mid_rst_valid", 32'(bus.m_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.wr_ptr = '0;
    @(negedge clk);
    chk("mid_valid", 32'(bus.m_valid), 0);
    chk("mid_rd_ptr", 32'(bus.rd_ptr), 0);
    chk("mid_ena", 32'(bus.ram_rd_port_ena), 0);
    chk("mid_empty", 32'(bus.empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
